// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one registered 32-bit ALU among NREQ requesters.
// One operation in flight; the result and requester ID are returned on a
// single valid/ready response channel.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (lowest index wins, no rr_ptr).
module alu_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*32-1:0]        req_a,
  input  logic [NREQ*32-1:0]        req_b,
  input  logic [NREQ*4-1:0]         req_sel,
  output logic [31:0]               alu_a,
  output logic [31:0]               alu_b,
  output logic [3:0]                alu_sel,
  input  logic [63:0]               alu_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [63:0]               rsp_data
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CNTW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [31:0]      alu_a_d, alu_b_d;
  logic [3:0]       alu_sel_d;
  logic             rsp_valid_d;
  logic [IDW-1:0]   rsp_id_d;
  logic [63:0]      rsp_data_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   rr_ptr, rr_ptr_d;
`endif

  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   scan_idx;

  logic [31:0]      op_a   [NREQ];
  logic [31:0]      op_b   [NREQ];
  logic [3:0]       op_sel [NREQ];

  // Unpack the flat per-requester operand buses.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g]   = req_a[g*32 +: 32];
    assign op_b[g]   = req_b[g*32 +: 32];
    assign op_sel[g] = req_sel[g*4 +: 4];
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Grant select: lowest valid index wins (scan downward, last hit is lowest).
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      scan_idx = IDW'(k);
      if (req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end
`else
  // Grant select: first valid index at or after rr_ptr, wrapping.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      scan_idx = IDW'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end
`endif

  // Next-state and datapath-next logic; req_ready is the combinational grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_sel_d   = alu_sel;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
    req_ready   = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          alu_a_d   = op_a[gnt_idx];
          alu_b_d   = op_b[gnt_idx];
          alu_sel_d = op_sel[gnt_idx];
          rsp_id_d  = gnt_idx;
          cnt_d     = CNTW'(ALU_LAT);
          state_d   = WAIT;
`ifndef ALU_ARB_FIXED_PRIO_EN
          rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`endif
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    // Keep the accept low while reset is held so no client sees a phantom grant.
    if (!rst) begin
      req_ready = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_sel   <= alu_sel_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_data  <= rsp_data_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Shares one registered 32-bit ALU (operands a/b, 4-bit op select, 64-bit result) among NREQ requesters. Each requester issues an operation on a valid/ready channel. The block arbitrates round-robin, drives the ALU operand ports, and waits the ALU's fixed latency. It then returns the 64-bit result with the requester ID on a single valid/ready response channel. It sits between the client blocks and the ALU instance; only one operation is in flight at a time.

## Interface
- NREQ, 4 — number of requesters (2..8)
- ALU_LAT, 1 — ALU clock-edge latency, from operands stable to result valid (1..4)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk)
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*32  operand A; requester i at [32i+31:32i]
- req_b  in  NREQ*32  operand B; same packing
- req_sel  in  NREQ*4  op select; requester i at [4i+3:4i]
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_sel  out  4  to ALU alu_sel
- alu_out  in  64  from ALU out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NREQ)  requester index of the result
- rsp_data  out  64  captured ALU result

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - If any req_valid is high, grant g = the first valid index at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - Handshake on that edge: latch req_a/req_b/req_sel of g into alu_a/alu_b/alu_sel; rsp_id<=g; rr_ptr<=(g+1) mod NREQ; cnt<=ALU_LAT; go to WAIT.
- WAIT:
  - req_ready is all-zero.
  - cnt decrements each cycle.
  - On the cycle with cnt==0: rsp_data<=alu_out, go to RESP.
- RESP:
  - rsp_valid=1.
  - When rsp_valid&rsp_ready: go to IDLE. There is no same-cycle re-arbitration.
- alu_sel is passed through uninterpreted; all 16 codes are legal.
- alu_a/alu_b/alu_sel hold their last latched values until the next accept.
- rsp_data and rsp_id are stable while rsp_valid&!rsp_ready.
- Requesters may drop req_valid before being granted. Arbitration uses only the current-cycle req_valid.
- A requester not granted keeps waiting; round-robin guarantees a grant within NREQ operations.

## Timing
- Reset values: state=IDLE, rr_ptr=0, cnt=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_a=0, alu_b=0, alu_sel=0.
- Accept in cycle 0:
  - ALU operands are stable from cycle 1.
  - WAIT occupies cycles 1..ALU_LAT+1.
  - rsp_valid rises in cycle ALU_LAT+2.
- Back-to-back throughput with rsp_ready held high: one operation per ALU_LAT+3 cycles.
- Reset mid-operation (WAIT or RESP) aborts the operation: no response, rr_ptr returns to 0.
- New req_valid during WAIT/RESP has no effect until IDLE.
- rsp_ready high in IDLE or WAIT is ignored.

## Configuration
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: grant is the lowest valid index (requester 0 highest). rr_ptr is not implemented, and the NREQ-operation fairness bound does not apply.
- Undefined (default): round-robin as in Operation.

## Test plan
- Reset then single op: req0 a=32'h1234ABCD, b=32'h00FF00FF, sel=4'h0 → req_ready[0] in the same cycle; rsp_valid at accept+3 (ALU_LAT=1); rsp_id=0; rsp_data = ALU's add result 64'h0000_0000_1333_ACCC.
- Sweep sel 0..15 on req2 with the same operands → each rsp_data matches the ALU reference model; alu_sel on the ALU port equals the issued code; rsp_id=2.
- All four req_valid held high for 8 ops → grant order 0,1,2,3,0,1,2,3. With ALU_ARB_FIXED_PRIO_EN: 0,0,0,… while req0 stays valid.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_valid/rsp_data/rsp_id stable; req_ready stays 0; next grant only after the response handshake.
- Assert rst low in WAIT → all outputs return to 0 asynchronously; no response is produced; after release, req3 alone is granted and completes normally.
- ALU_LAT=3 build → rsp_valid exactly 5 cycles after accept; a req_valid pulse dropped before grant is never accepted.
